// File: rtl/approx_add_pkg.sv
// ----------------------------------------------------------------------------
// approx_add_pkg
// Shared types and constants for the approximate-adder scheduler.
//   sched_state_t : scheduler FSM state (IDLE -> EXEC -> RESP)
//   ERR_CNT_W     : width of the erroneous-response counter
//   ERR_CNT_MAX   : saturation value of that counter
// ----------------------------------------------------------------------------
package approx_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of req searching
// upward from ptr, wrapping modulo NREQ.
// Ports:
//   req        [NREQ] in  : request vector
//   ptr        [IDW]  in  : highest-priority index (always < NREQ)
//   gnt_onehot [NREQ] out : one-hot grant, zero when req is zero
//   gnt_idx    [IDW]  out : index of the granted bit, zero when req is zero
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx
);

    // One extra bit so ptr+k cannot overflow before the modulo fold.
    logic [IDW:0] cand;
    logic         found;

    always_comb begin
        cand       = '0;
        found      = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            // Constant-index compare keeps the request lookup width-exact.
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (cand == (IDW+1)'(j)) && req[j]) begin
                    found   = 1'b1;
                    gnt_idx = IDW'(j);
                end
            end
        end
        for (int j = 0; j < NREQ; j++)
            gnt_onehot[j] = found && (gnt_idx == IDW'(j));
    end

endmodule

// File: rtl/approx_add_sched.sv
// ----------------------------------------------------------------------------
// approx_add_sched
// Round-robin scheduler sharing one combinational approximate adder among
// NREQ requesters. One operation takes IDLE (grant) -> EXEC (adder sees the
// registered operands, result captured) -> RESP (held until rsp_ready).
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b         : packed operands, requester i at [i*W +: W]
//   add_a, add_b         : operands to the shared adder (0 while IDLE)
//   add_sum              : adder result, W+1 bits
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id, rsp_sum      : granted requester index and captured result
//   err_flag, err_count  : approximate-vs-exact mismatch flag and saturating
//                          count of accepted erroneous responses
//
// Build option: define APPROX_ADD_ERR_CHECK_EN to build the exact-sum check;
// without it err_flag and err_count are constant 0 and no exact adder exists.
// ----------------------------------------------------------------------------
module approx_add_sched
    import approx_add_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*W-1:0]    req_a,
    input  logic [NREQ*W-1:0]    req_b,
    output logic [W-1:0]         add_a,
    output logic [W-1:0]         add_b,
    input  logic [W:0]           add_sum,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W:0]           rsp_sum,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_count
);

    sched_state_t    state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_id;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W:0]      rsp_sum_q;

    logic [NREQ-1:0] gnt_onehot;
    logic [IDW-1:0]  gnt_idx;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_onehot[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    // Ready is gated by rst_n so no request is taken while reset is held.
    assign req_ready = (state == IDLE && rst_n) ? gnt_onehot : '0;
    assign add_a     = (state == IDLE) ? '0 : op_a;
    assign add_b     = (state == IDLE) ? '0 : op_b;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = gnt_id;
    assign rsp_sum   = rsp_sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_sum_q <= '0;
        end else begin
            case (state)
                // Grant: latch the winner's operands and index.
                IDLE: begin
                    if (|req_valid) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        gnt_id <= gnt_idx;
                        state  <= EXEC;
                    end
                end
                // Adder sees op_a/op_b this cycle; capture its result.
                EXEC: begin
                    rsp_sum_q <= add_sum;
                    state     <= RESP;
                end
                // Hold the response; advance the pointer past the winner.
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef APPROX_ADD_ERR_CHECK_EN
    logic [W:0]           exact_sum;
    logic                 err_flag_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign exact_sum = {1'b0, op_a} + {1'b0, op_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            // Flag is captured on the same edge as rsp_sum.
            if (state == EXEC)
                err_flag_q <= (exact_sum != add_sum);
            // Count only responses actually accepted.
            if (state == RESP && rsp_ready && err_flag_q)
                err_count_q <= sat_inc(err_count_q);
        end
    end

    assign err_flag  = err_flag_q;
    assign err_count = err_count_q;
`else
    assign err_flag  = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_approx_add_sched.sv
// ----------------------------------------------------------------------------
// tb_approx_add_sched
// Self-checking bench for approx_add_sched (NREQ=4, W=8). A behavioural
// adder model (exact or a+b-1) drives add_sum; a monitor pushes the expected
// response on every request handshake and the scenario tasks pop and compare
// when the DUT responds.
// ----------------------------------------------------------------------------
module tb_approx_add_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

`ifdef APPROX_ADD_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W:0]        add_sum;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W:0]        rsp_sum;
    logic              err_flag;
    logic [15:0]       err_count;

    logic              approx_mode;
    logic [15:0]       exp_cnt;
    int                checks = 0;
    int                errors = 0;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W:0]     sum;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (m) s = s - (W+1)'(1);
        return s;
    endfunction

    assign add_sum = model(approx_mode, add_a, add_b);

    approx_add_sched #(
        .NREQ (NREQ),
        .W    (W),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .err_flag  (err_flag),
        .err_count (err_count)
    );

    // Scoreboard producer: one expectation per request handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_e.id  = IDW'(i);
                    mon_e.sum = model(approx_mode, req_a[i*W +: W], req_b[i*W +: W]);
                    sb.push_back(mon_e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] cnt_next(input logic [15:0] v, input bit err);
        if (ERR_EN && err && v != 16'hFFFF) return v + 16'd1;
        return v;
    endfunction

    task automatic do_reset;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        exp_cnt = '0;
    endtask

    // Returns at the negedge where rsp_valid is seen, or after max cycles.
    task automatic wait_rsp(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Drive one request, hold it until accepted, then drop valid (EXEC cycle).
    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
        @(posedge clk);
        #1;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[id] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        approx_mode = 1'b0;
        rsp_ready   = 1'b0;
        req_valid   = '1;
        req_a       = '0;
        req_b       = '0;
        exp_cnt     = '0;
        @(negedge clk);
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (add_a !== '0 || add_b !== '0) begin errors++; $display("FAIL reset_add_ops: got %h/%h want 00/00", add_a, add_b); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== '0 || rsp_sum !== '0) begin errors++; $display("FAIL reset_rsp_data: got id=%0d sum=%h want 0/000", rsp_id, rsp_sum); end
        checks++; if (err_flag !== 1'b0 || err_count !== 16'h0) begin errors++; $display("FAIL reset_err: got flag=%b cnt=%h want 0/0000", err_flag, err_count); end
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== '0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_quiet: got ready=%b vld=%b want 0000/0", req_ready, rsp_valid); end
    endtask

    task automatic test_single;
        exp_t e;
        approx_mode = 1'b0;
        rsp_ready   = 1'b1;
        @(posedge clk);
        #1;
        req_a[2*W +: W] = 8'h0F;
        req_b[2*W +: W] = 8'h01;
        req_valid       = 4'b0100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
        checks++; if (add_a !== 8'h0F || add_b !== 8'h01) begin errors++; $display("FAIL single_add_ops: got %h/%h want 0f/01", add_a, add_b); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 9'h010) begin errors++; $display("FAIL single_rsp: got vld=%b id=%0d sum=%h want 1/2/010", rsp_valid, rsp_id, rsp_sum); end
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL single_sb: got empty scoreboard want 1 entry"); end
        else begin
            e = sb.pop_front();
            if (rsp_id !== e.id || rsp_sum !== e.sum) begin errors++; $display("FAIL single_sb: got id=%0d sum=%h want id=%0d sum=%h", rsp_id, rsp_sum, e.id, e.sum); end
        end
        checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL single_err_flag: got %b want 0", err_flag); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin;
        exp_t e;
        int   nrsp;
        int   last_cyc;
        do_reset();
        approx_mode = 1'b0;
        rsp_ready   = 1'b1;
        nrsp        = 0;
        last_cyc    = 0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(16*i + 3);
            req_b[i*W +: W] = W'(i + 5);
        end
        req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                checks++; if (rsp_id !== IDW'(nrsp % NREQ)) begin errors++; $display("FAIL rr_order[%0d]: got id=%0d want %0d", nrsp, rsp_id, nrsp % NREQ); end
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rr_sb[%0d]: got empty scoreboard want entry", nrsp); end
                else begin
                    e = sb.pop_front();
                    if (rsp_id !== e.id || rsp_sum !== e.sum) begin errors++; $display("FAIL rr_sb[%0d]: got id=%0d sum=%h want id=%0d sum=%h", nrsp, rsp_id, rsp_sum, e.id, e.sum); end
                end
                if (nrsp > 0) begin
                    checks++; if (c - last_cyc != 3) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles want 3", nrsp, c - last_cyc); end
                end
                last_cyc = c;
                nrsp++;
                if (nrsp == 5) break;
            end
        end
        checks++; if (nrsp != 5) begin errors++; $display("FAIL rr_count: got %0d responses want 5", nrsp); end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rr_leftover: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_backpressure;
        exp_t e;
        bit   ok;
        rsp_ready = 1'b0;
        issue(1, 8'h33, 8'h44, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_grant1: got no req_ready want grant within 20 cycles"); end
        req_a[3*W +: W] = 8'h05;
        req_b[3*W +: W] = 8'h06;
        req_valid[3]    = 1'b1;
        wait_rsp(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_rsp_timeout: got no rsp_valid want response"); end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 9'h077) begin errors++; $display("FAIL bp_rsp_hold[%0d]: got vld=%b id=%0d sum=%h want 1/1/077", c, rsp_valid, rsp_id, rsp_sum); end
            checks++; if (add_a !== 8'h33 || add_b !== 8'h44) begin errors++; $display("FAIL bp_ops_hold[%0d]: got %h/%h want 33/44", c, add_a, add_b); end
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_no_ready[%0d]: got %b want 0000", c, req_ready); end
        end
        rsp_ready = 1'b1;
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_sb1: got empty scoreboard want entry"); end
        else begin
            e = sb.pop_front();
            if (rsp_id !== e.id || rsp_sum !== e.sum) begin errors++; $display("FAIL bp_sb1: got id=%0d sum=%h want id=%0d sum=%h", rsp_id, rsp_sum, e.id, e.sum); end
        end
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready !== '0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok || req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant3: got %b want 1000", req_ready); end
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        wait_rsp(10, ok);
        checks++;
        if (!ok || sb.size() == 0) begin errors++; $display("FAIL bp_sb3: got vld=%b pending=%0d want response", ok, sb.size()); end
        else begin
            e = sb.pop_front();
            if (rsp_id !== e.id || rsp_sum !== e.sum) begin errors++; $display("FAIL bp_sb3: got id=%0d sum=%h want id=%0d sum=%h", rsp_id, rsp_sum, e.id, e.sum); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_err;
        exp_t e;
        bit   ok;
        bit   ok2;
        for (int pass = 0; pass < 2; pass++) begin
            approx_mode = (pass == 0);
            rsp_ready   = 1'b0;
            issue(0, 8'hFF, 8'hFF, ok);
            wait_rsp(10, ok2);
            checks++; if (!(ok && ok2)) begin errors++; $display("FAIL err_timeout[%0d]: got grant=%b rsp=%b want 1/1", pass, ok, ok2); end
            checks++; if (rsp_sum !== ((pass == 0) ? 9'h1FD : 9'h1FE)) begin errors++; $display("FAIL err_sum[%0d]: got %h want %h", pass, rsp_sum, (pass == 0) ? 9'h1FD : 9'h1FE); end
            checks++; if (err_flag !== (ERR_EN && pass == 0)) begin errors++; $display("FAIL err_flag[%0d]: got %b want %b", pass, err_flag, ERR_EN && pass == 0); end
            checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL err_cnt_pre[%0d]: got %h want %h", pass, err_count, exp_cnt); end
            rsp_ready = 1'b1;
            checks++;
            if (sb.size() == 0) begin errors++; $display("FAIL err_sb[%0d]: got empty scoreboard want entry", pass); end
            else begin
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_sum !== e.sum) begin errors++; $display("FAIL err_sb[%0d]: got id=%0d sum=%h want id=%0d sum=%h", pass, rsp_id, rsp_sum, e.id, e.sum); end
            end
            exp_cnt = cnt_next(exp_cnt, pass == 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL err_cnt_post[%0d]: got %h want %h", pass, err_count, exp_cnt); end
        end
    endtask

    task automatic test_saturation;
        exp_t e;
        bit   ok;
        bit   ok2;
`ifdef APPROX_ADD_ERR_CHECK_EN
        @(negedge clk);
        force dut.err_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_count_q;
        exp_cnt = 16'hFFFE;
`endif
        approx_mode = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rsp_ready = 1'b1;
            issue(k + 1, 8'h80, 8'h80, ok);
            wait_rsp(10, ok2);
            checks++;
            if (!(ok && ok2) || sb.size() == 0) begin errors++; $display("FAIL sat_rsp[%0d]: got grant=%b rsp=%b want response", k, ok, ok2); end
            else begin
                e = sb.pop_front();
                if (rsp_id !== e.id || rsp_sum !== e.sum) begin errors++; $display("FAIL sat_rsp[%0d]: got id=%0d sum=%h want id=%0d sum=%h", k, rsp_id, rsp_sum, e.id, e.sum); end
            end
            exp_cnt = cnt_next(exp_cnt, 1'b1);
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL sat_count[%0d]: got %h want %h", k, err_count, exp_cnt); end
        end
        approx_mode = 1'b0;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bit   ok;
        int   seen;
        rsp_ready = 1'b1;
        // Pointer is currently non-zero (last grant went to requester 2).
        issue(0, 8'h21, 8'h12, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_grant: got no req_ready want grant"); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== '0) begin errors++; $display("FAIL mid_ctrl: got vld=%b ready=%b want 0/0000", rsp_valid, req_ready); end
        checks++; if (add_a !== '0 || add_b !== '0) begin errors++; $display("FAIL mid_ops: got %h/%h want 00/00", add_a, add_b); end
        checks++; if (rsp_id !== '0 || rsp_sum !== '0) begin errors++; $display("FAIL mid_rsp_data: got id=%0d sum=%h want 0/000", rsp_id, rsp_sum); end
        checks++; if (err_flag !== 1'b0 || err_count !== 16'h0) begin errors++; $display("FAIL mid_err: got flag=%b cnt=%h want 0/0000", err_flag, err_count); end
        sb.delete();
        exp_cnt = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_rsp: got %0d response cycles want 0", seen); end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(i + 1);
            req_b[i*W +: W] = W'(2*i + 7);
        end
        req_valid = '1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr_zero: got %b want 0001", req_ready); end
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_rsp(10, ok);
        checks++;
        if (!ok || sb.size() == 0) begin errors++; $display("FAIL mid_after_rsp: got vld=%b pending=%0d want response", ok, sb.size()); end
        else begin
            e = sb.pop_front();
            if (rsp_id !== e.id || rsp_sum !== e.sum) begin errors++; $display("FAIL mid_after_rsp: got id=%0d sum=%h want id=%0d sum=%h", rsp_id, rsp_sum, e.id, e.sum); end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_err();
        test_saturation();
        test_reset_mid();
        @(negedge clk);
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL final_sb: got %0d pending want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
